uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one UART_Transmit; legal range 2..8.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge; one clock only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  NREQ  per-requester level request; the requester holds it until acked.
REQ-005 req_data  input  8*NREQ  packed bytes; requester i uses bits [8i+7:8i], held stable while req[i]=1.
REQ-006 txrdy  input  1  ready flag from the UART transmitter; 1 = idle, able to accept a byte.
REQ-007 ack  output  NREQ  one-cycle pulse to the requester whose byte was issued.
REQ-008 load  output  1  one-cycle Load strobe to the UART transmitter.
REQ-009 out_port  output  8  byte to the UART transmitter; valid and stable in the load cycle.
REQ-010 grant  output  NREQ  one-hot owner of the current transaction; all zero when idle.
REQ-011 busy  output  1  1 in any state other than IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-013 IDLE -> LOAD when txrdy=1 and req!=0: register the winner's index, set grant, and capture that requester's byte into out_port.
REQ-014 IDLE with txrdy=0 or req=0: remain in IDLE; load=0, ack=0, grant=0.
REQ-015 LOAD lasts exactly one cycle: load=1 and ack[winner]=1, then go to WAIT_BUSY.
REQ-016 WAIT_BUSY -> WAIT_DONE on the first cycle txrdy=0.
REQ-017 WAIT_DONE -> IDLE on the first cycle txrdy=1; update the round-robin pointer to the winner's index.
REQ-018 Latency: req asserted in cycle n with the arbiter idle and txrdy=1 -> load and ack in cycle n+1.
REQ-019 At most one load per transmitted character; no new arbitration while busy=1.
REQ-020 Round-robin: search starts at pointer+1 and wraps modulo NREQ; the first set req bit wins.
REQ-021 A requester that deasserts req before winning is simply skipped; no ack is issued to it.
REQ-022 out_port SHALL hold the last issued byte until the next LOAD; it does not track req_data.
REQ-023 A requester whose req stays high after its ack is treated as a new request and competes normally.
REQ-024 With any unused NREQ slots tied to 0, behaviour SHALL be identical to a smaller NREQ.

Reset
REQ-025 On reset: state=IDLE, load=0, ack=0, grant=0, busy=0, out_port=8'h00, pointer=NREQ-1 (requester 0 wins first).
REQ-026 Reset asserted mid-transaction SHALL abort on the next edge with no further load or ack; the UART is reset by the same signal.

Configuration
REQ-027 Macro UART_TX_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with the lowest index winning, and the pointer is not implemented.
REQ-028 When UART_TX_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-020 applies.
REQ-029 The FSM, latency and ports SHALL be identical in both builds.

Verification
REQ-030 Reset, then req=4'b0001, data0=8'h41, txrdy=1 -> next cycle load=1, ack=4'b0001, out_port=8'h41, grant=4'b0001.
REQ-031 txrdy model drops 1 cycle after load and rises 100 cycles later -> busy=1 throughout, no second load; IDLE on the cycle after txrdy rises.
REQ-032 req=4'b1111 held, round-robin build -> acks in the order 0,1,2,3,0 across five transactions.
REQ-033 Same stimulus with UART_TX_ARB_FIXED_PRIO_EN defined -> acks 0,0,0 while req[0] stays high.
REQ-034 req=4'b0100 with txrdy=0 -> no load until txrdy=1, then load the next cycle with data2.
REQ-035 Reset pulsed while in WAIT_DONE -> outputs at reset values on the next cycle, no stray ack or load.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NREQ byte requesters, the arbiter and one UART transmitter.
// The master side drives requests and the txrdy flag; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic              txrdy;
    logic [NREQ-1:0]   ack;
    logic              load;
    logic [7:0]        out_port;
    logic [NREQ-1:0]   grant;
    logic              busy;

    modport master (
        output req, req_data, txrdy,
        input  ack, load, out_port, grant, busy
    );

    modport slave (
        input  req, req_data, txrdy,
        output ack, load, out_port, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters: round-robin by default, fixed priority
// (lowest index wins) when UART_TX_ARB_FIXED_PRIO_EN is defined. Load/ack one cycle after request.
// Backpressure: no arbitration until the UART has gone busy (txrdy=0) and idle (txrdy=1) again.
module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic            found;
    logic            take;
    logic [7:0]      out_q;
    logic [NREQ-1:0] win_onehot;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win_d = '0;
        // Descending scan so the lowest set index is the last (winning) assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                found = 1'b1;
                win_d = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        win_d = '0;
        cand  = '0;
        // Search begins just after the last winner; offset NREQ revisits the last winner itself.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win_d = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= IW'(NREQ - 1);
        end else if (state_q == WAIT_DONE && bus.txrdy) begin
            ptr_q <= win_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.txrdy && found) begin
                    state_d = LOAD;
                    take    = 1'b1;
                end
            end
            LOAD:      state_d = WAIT_BUSY;
            WAIT_BUSY: if (!bus.txrdy) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.txrdy)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (take) begin
                win_q <= win_d;
                out_q <= bus.req_data[{win_d, 3'b000} +: 8];
            end
        end
    end

    assign win_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.load     = (state_q == LOAD);
    assign bus.grant    = (state_q != IDLE) ? win_onehot : '0;
    assign bus.ack      = (state_q == LOAD) ? win_onehot : '0;
    assign bus.out_port = out_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; expected grants are queued by the stimulus
// and a separate monitor checks each load against the queue head.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    int order[5] = '{0, 0, 0, 0, 0};
    int idx_1001 = 0;
`else
    int order[5] = '{0, 1, 2, 3, 0};
    int idx_1001 = 3;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx  = idx;
        e.data = bus.req_data[8*idx +: 8];
        expq.push_back(e);
    endtask

    // Advances at least one cycle, then up to maxc more, until load appears.
    task automatic wait_load(input int maxc, input string name);
        int c = 0;
        tick();
        while (bus.load !== 1'b1 && c < maxc) begin
            tick();
            c++;
        end
        check(name, 32'(bus.load), 32'd1);
    endtask

    // Called in the load cycle: UART drops txrdy one cycle later, raises it n cycles after that.
    task automatic uart_tx(input int n);
        tick();
        bus.txrdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("busy_during_tx", 32'(bus.busy), 32'd1);
        end
        bus.txrdy = 1'b1;
        tick();
        check("idle_after_txrdy", 32'(bus.busy), 32'd0);
        check("grant_idle", 32'(bus.grant), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_load"},     32'(bus.load),     32'd0);
        check({tag, "_ack"},      32'(bus.ack),      32'd0);
        check({tag, "_grant"},    32'(bus.grant),    32'd0);
        check({tag, "_out_port"}, 32'(bus.out_port), 32'd0);
    endtask

    initial begin
        forever begin
            tick();
            if (bus.load === 1'b1) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: ack=%0h out_port=%0h, expected no load", bus.ack, bus.out_port);
                end else begin
                    mon_e = expq.pop_front();
                    check("mon_ack",      32'(bus.ack),      32'(1) << mon_e.idx);
                    check("mon_grant",    32'(bus.grant),    32'(1) << mon_e.idx);
                    check("mon_out_port", 32'(bus.out_port), 32'(mon_e.data));
                end
            end else if (bus.ack !== '0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ack_without_load: ack=%0h, expected 0", bus.ack);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req      = '0;
        bus.req_data = {8'h44, 8'h43, 8'h42, 8'h41};
        bus.txrdy    = 1'b1;
        reset        = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single request: load/ack one cycle later, then a 100-cycle character time.
        bus.req = 4'b0001;
        push_exp(0);
        wait_load(0, "latency_req0");
        bus.req = '0;
        uart_tx(100);
        check("out_port_kept", 32'(bus.out_port), 32'h41);

        // All requesting continuously from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push_exp(order[i]);
            wait_load(0, "latency_all");
            uart_tx(3);
        end
        bus.req = '0;
        tick();

        // Pointer-dependent picks (last winner is 0).
        bus.req = 4'b1010;
        push_exp(1);
        wait_load(0, "latency_1010");
        bus.req = '0;
        uart_tx(3);
        bus.req = 4'b1001;
        push_exp(idx_1001);
        wait_load(0, "latency_1001");
        bus.req = '0;
        uart_tx(3);

        // UART not ready: no load; requester 3 withdraws unserved; then requester 2 goes.
        bus.txrdy = 1'b0;
        bus.req   = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_load_txrdy0", 32'(bus.load), 32'd0);
        end
        bus.req = 4'b0100;
        tick();
        check("no_load_txrdy0_b", 32'(bus.busy), 32'd0);
        bus.txrdy = 1'b1;
        push_exp(2);
        wait_load(0, "latency_txrdy_rise");
        bus.req = '0;
        bus.req_data[23:16] = 8'hEE;
        uart_tx(3);
        check("out_port_not_tracking", 32'(bus.out_port), 32'h43);
        bus.req_data[23:16] = 8'h43;

        // Reset while waiting for the character to finish.
        bus.req = 4'b0001;
        push_exp(0);
        wait_load(0, "latency_pre_abort");
        bus.req = '0;
        tick();
        bus.txrdy = 1'b0;
        tick();
        tick();
        check("busy_in_wait_done", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        bus.txrdy = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("no_load_after_abort", 32'(bus.load), 32'd0);

        // Arbiter serves again after the abort.
        bus.req = 4'b0010;
        push_exp(1);
        wait_load(0, "latency_after_abort");
        bus.req = '0;
        uart_tx(2);

        tick();
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
